nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle N-bit adder that walks two latched WIDTH-bit operands through one internal 4-bit carry-lookahead slice, one nibble per clock, least-significant nibble first. The inter-nibble carry is held in a register. It sits in front of the datapath's result consumers, turning the 4-bit lookahead slice into a wide adder with a valid/ready request interface and a valid/ready result interface. It trades latency for area in blocks where a full-width lookahead tree is not justified.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result held on sum/cout/overflow.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN and DONE.

## Operation
- **States:** IDLE, RUN, DONE. Reset forces IDLE.
- **Reset values:** sum=0, cout=0, overflow=0, out_valid=0, busy=0, nibble index=0, carry register=0. in_ready=1 (combinational: state==IDLE).
- **IDLE:**
  - On an edge with in_valid & in_ready: latch a, b, and cin into the carry register; clear the index; go to RUN.
  - If in_valid is low, stay in IDLE.
- **RUN, one nibble per cycle at index i:**
  - Slice inputs: x=a[4i+3:4i], y=b[4i+3:4i], c0=carry register.
  - Propagate p=x^y; generate g=x&y.
  - Carries: c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3=g2|p2g1|p2p1g0|p2p1p0c0; c4=g3|p3c3 in full lookahead form.
  - Nibble sum = p^{c3,c2,c1,c0}.
- **RUN register updates each edge:**
  - sum[4i+3:4i] gets the nibble sum.
  - The carry register gets c4.
  - i increments.
- **Last nibble (i==NIB-1), on that edge:**
  - cout gets c4; overflow gets c3^c4.
  - out_valid is set; go to DONE.
- **DONE:**
  - sum, cout and overflow are held stable.
  - On an edge with out_valid & out_ready: clear out_valid and go to IDLE. Otherwise hold indefinitely.
- **Operand capture:**
  - Operands are sampled only at acceptance; a, b and cin may change freely afterwards.
  - in_valid during RUN or DONE is ignored; no request is queued.
- **sum visibility:** sum is defined only while out_valid=1. During RUN it holds a mix of new low nibbles and stale upper nibbles.
- **Reset mid-operation:** any assertion of rst aborts immediately (asynchronously) and all outputs return to reset values. The in-flight request is lost; no partial result is ever flagged valid.
- **Arithmetic:** unsigned modulo 2^WIDTH. cout and overflow serve unsigned and signed callers respectively.

## Timing
- Acceptance at edge T0. RUN occupies edges T1..T_NIB. out_valid rises after edge T_NIB, i.e. latency NIB cycles (4 for WIDTH=16, 1 for WIDTH=4).
- With out_ready held high, out_valid stays up for exactly one cycle. The return to IDLE happens at the handshake edge, and in_ready is high the following cycle.
- Minimum initiation interval is NIB+2 cycles: accept, NIB RUN cycles, DONE handshake.
- All outputs except in_ready are registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.
- The critical path is one 4-bit lookahead slice plus the operand nibble mux, independent of WIDTH.

## Test plan
All scenarios use WIDTH=16.
- **Full carry ripple:** 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. out_valid first high exactly 4 cycles after the accept edge.
- **Signed overflow:** 0x7FFF + 0x0001 → sum=0x8000, cout=0, overflow=1. Separately, 0x8000 + 0x8000 → sum=0x0000, cout=1, overflow=1.
- **Carry-in and operand capture:** 0x1234 + 0x4321 with cin=1 → sum=0x5556, cout=0, overflow=0.
  - Drive a=0xFFFF, b=0xFFFF, in_valid=1 during RUN; the result stays 0x5556.
  - in_ready stays 0 throughout RUN and DONE.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid rises. sum, cout, overflow and out_valid stay stable, busy=1, in_ready=0.
  - Raise out_ready: out_valid drops after that edge.
  - A back-to-back request 0x0001 + 0x0002 is accepted the next cycle → 0x0003.
- **Reset mid-RUN:** assert rst after 2 nibbles of 0xABCD + 0x1111. Immediately out_valid=0, busy=0, sum=0, cout=0.
  - After release, in_ready=1.
  - 0x0005 + 0x0003 then yields 0x0008, with no trace of the aborted result.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit carry-lookahead slice, reused one nibble per clock.
// The nibbles are processed least significant first, with the inter-nibble carry held in a register.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [3:0]       x_nib, y_nib;
    logic [5:0]       slice;
    logic [WIDTH-1:0] sum_nxt;
    logic             last;

    // Returns {c4, c3, nibble_sum}; c3 is kept so overflow can be formed on the top nibble.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p, g;
        logic       c1, c2, c3, c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    always_comb begin
        x_nib   = '0;
        y_nib   = '0;
        sum_nxt = sum;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IDX_W'(k)) begin
                x_nib = a_q[4*k +: 4];
                y_nib = b_q[4*k +: 4];
            end
        end
        slice = cla4(x_nib, y_nib, carry_q);
        for (int k = 0; k < NIB; k++) begin
            if (idx == IDX_W'(k)) sum_nxt[4*k +: 4] = slice[3:0];
        end
    end

    assign last     = (idx == IDX_W'(NIB - 1));
    assign in_ready = (state == IDLE);

    // Operand registers carry data only; they are qualified by the FSM, so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_valid && (state == IDLE)) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_q <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum     <= sum_nxt;
                    carry_q <= slice[5];
                    idx     <= idx + 1'b1;
                    if (last) begin
                        cout      <= slice[5];
                        overflow  <= slice[5] ^ slice[4];
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: arithmetic/handshake reference model plus directed literal cases.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer addition plus a countdown for the NIB-cycle latency.
    logic [WIDTH:0]   full;
    logic             m_busy = 1'b0, m_valid = 1'b0, m_zero = 1'b1;
    int               m_cnt = 0;
    logic [WIDTH-1:0] pend_sum = '0, exp_sum = '0;
    logic             pend_cout = 1'b0, pend_ovf = 1'b0, exp_cout = 1'b0, exp_ovf = 1'b0;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_zero   <= 1'b1;
            m_cnt    <= 0;
            exp_sum  <= '0;
            exp_cout <= 1'b0;
            exp_ovf  <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy    <= 1'b1;
                m_zero    <= 1'b0;
                m_cnt     <= NIB;
                pend_sum  <= full[WIDTH-1:0];
                pend_cout <= full[WIDTH];
                pend_ovf  <= (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid  <= 1'b1;
                exp_sum  <= pend_sum;
                exp_cout <= pend_cout;
                exp_ovf  <= pend_ovf;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("in_ready", in_ready, !m_busy);
        if (m_valid || m_zero) begin
            chk("sum", sum, exp_sum);
            chk("cout", cout, exp_cout);
            chk("overflow", overflow, exp_ovf);
        end
    end

    // Entered and left at a negedge. poke drives junk requests while the add is in flight.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input bit lit, input bit poke, input int hold);
        int w;
        int cyc;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", (w < 50), 1);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            if (poke) begin
                in_valid = 1'b1;
                a        = 16'hFFFF;
                b        = 16'hFFFF;
                chk("in_ready_run", in_ready, 0);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", cyc, NIB);
        if (lit) begin
            chk("lit_sum", sum, es);
            chk("lit_cout", cout, ec);
            chk("lit_ovf", overflow, eo);
        end
        for (int h = 0; h < hold; h++) begin
            if (poke) in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_in_ready", in_ready, 0);
            if (lit) chk("hold_sum", sum, es);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_valid_drop", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1, 1, 2);
        do_op(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1, 0, 5);
        do_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1, 0, 0);

        // Abort an add of 0xABCD + 0x1111 after two nibbles have been written.
        a        = 16'hABCD;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1, 0, 0);

        for (int n = 0; n < 150; n++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), '0, 1'b0, 1'b0,
                  0, bit'($urandom_range(0, 1)), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
